// File: rtl/conway_ctrl_pkg.sv
// Shared types and default widths for the Game-of-Life generation controller.
package conway_ctrl_pkg;

    // Controller states; the 3-bit encoding is driven directly on the state port.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        INIT = 3'd2,
        RUN  = 3'd3,
        HALT = 3'd4
    } ctrl_state_t;

    localparam int TICK_W_DEF = 24;
    localparam int GEN_W_DEF  = 16;

    // Last tick index of a generation period; a period of 0 behaves like 1.
    function automatic logic [TICK_W_DEF-1:0] last_tick_def(input logic [TICK_W_DEF-1:0] period);
        return (period == '0) ? '0 : period - TICK_W_DEF'(1);
    endfunction

endpackage

// File: rtl/conway_gen_timer.sv
// Generation period timer: counts enabled cycles and flags the last cycle of each period.
// expire is high for one enabled cycle when the count reaches max(period,1)-1; the count
// then returns to 0. While en is low the count holds and expire stays low.
module conway_gen_timer #(
    parameter int TICK_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [TICK_W-1:0] period,
    output logic              expire,
    output logic [TICK_W-1:0] tick
);

    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] last_tick;

    assign last_tick = (period == '0) ? '0 : period - TICK_W'(1);
    assign expire    = en && (tick_q == last_tick);
    assign tick      = tick_q;

    // Tick counter: cleared outside RUN, advances only while enabled, wraps at expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else if (clr) begin
            tick_q <= '0;
        end else if (en) begin
            if (expire) begin
                tick_q <= '0;
            end else begin
                tick_q <= tick_q + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/conway_gen_controller.sv
// Game-of-Life array sequencer: loads a pattern row by row, holds the cells in load,
// then paces generations with one-cycle grid_ena pulses, with pause/step and a limit.
// Optional build macro CONWAY_STABLE_DETECT_EN halts on a still life (stable=1).
//
// Row handshake: a row transfers on a rising clk edge where row_valid && row_ready;
// row_ready is high exactly while the FSM is in LOAD and does not depend on row_valid.
module conway_gen_controller import conway_ctrl_pkg::*; #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int TICK_W = TICK_W_DEF,
    parameter int GEN_W  = GEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 step,
    input  logic [TICK_W-1:0]    period,
    input  logic [GEN_W-1:0]     max_gen,
    input  logic [COLS-1:0]      row_data,
    input  logic                 row_valid,
    output logic                 row_ready,
    input  logic                 grid_changed,
    output logic [ROWS*COLS-1:0] grid_state_0,
    output logic                 grid_rst,
    output logic                 grid_ena,
    output logic [GEN_W-1:0]     gen_count,
    output logic [2:0]           state,
    output logic                 done,
    output logic                 stable
);

    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    ctrl_state_t           state_q;
    ctrl_state_t           state_d;
    logic [IDX_W-1:0]      row_idx_q;
    logic [ROWS*COLS-1:0]  grid_q;
    logic [GEN_W-1:0]      gen_count_q;
    logic                  grid_rst_q;
    logic                  grid_ena_q;
    logic                  done_q;
    logic                  stable_q;

    logic                  load_start;
    logic                  row_accept;
    logic                  last_row;
    logic                  timer_en;
    logic                  timer_clr;
    logic                  tick_expire;
    logic [TICK_W-1:0]     tick_value;
    logic                  gen_fire;
    logic                  gen_limit_hit;
    logic                  still_life;
    logic                  enter_halt;
    logic                  unused_tick;

    // ------------------------------------------------------------------
    // Generation timer: runs only in RUN and only while not paused, so a
    // pause on the expiry cycle defers the expiry to the first free cycle.
    // ------------------------------------------------------------------
    assign timer_en  = (state_q == RUN) && !pause;
    assign timer_clr = (state_q != RUN);

    conway_gen_timer #(
        .TICK_W (TICK_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (timer_en),
        .clr    (timer_clr),
        .period (period),
        .expire (tick_expire),
        .tick   (tick_value)
    );

    assign unused_tick = ^tick_value;

    // ------------------------------------------------------------------
    // Handshake and generation strobes
    // ------------------------------------------------------------------
    assign row_ready  = (state_q == LOAD);
    assign row_accept = row_valid && row_ready;
    assign last_row   = (row_idx_q == IDX_W'(ROWS - 1));

    // A pulse is never issued in the cycle right after another pulse, which
    // keeps at least one idle cycle between pulses for period<=1 and for
    // back-to-back steps (a step landing on a pulse cycle is dropped).
    assign gen_fire = (state_q == RUN) && !grid_ena_q && (pause ? step : tick_expire);

    // gen_count already holds the incremented value during the pulse cycle.
    assign gen_limit_hit = (max_gen != '0) && (gen_count_q == max_gen);

`ifdef CONWAY_STABLE_DETECT_EN
    // grid_changed is captured on the edge that ends the pulse cycle.
    assign still_life = grid_ena_q && !grid_changed;
`else
    logic unused_grid_changed;
    assign unused_grid_changed = grid_changed;
    assign still_life          = 1'b0;
`endif

    assign enter_halt = (state_q == RUN) && (state_d == HALT);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start is honoured only in IDLE and HALT.
    always_comb begin
        state_d    = state_q;
        load_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    load_start = 1'b1;
                end
            end
            LOAD: begin
                if (row_accept && last_row) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                state_d = RUN;
            end
            RUN: begin
                if (grid_ena_q && (still_life || gen_limit_hit)) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (start) begin
                    state_d    = LOAD;
                    load_start = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs, row index and generation count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid_rst_q  <= 1'b1;
            grid_ena_q  <= 1'b0;
            row_idx_q   <= '0;
            gen_count_q <= '0;
            done_q      <= 1'b0;
            stable_q    <= 1'b0;
        end else begin
            grid_rst_q <= (state_d == IDLE) || (state_d == LOAD) || (state_d == INIT);
            grid_ena_q <= gen_fire;
            if (load_start) begin
                row_idx_q   <= '0;
                gen_count_q <= '0;
                done_q      <= 1'b0;
                stable_q    <= 1'b0;
            end else begin
                if (row_accept) begin
                    row_idx_q <= row_idx_q + IDX_W'(1);
                end
                if (gen_fire) begin
                    gen_count_q <= gen_count_q + GEN_W'(1);
                end
                if (enter_halt) begin
                    done_q   <= 1'b1;
                    stable_q <= still_life;
                end
            end
        end
    end

    // Initial-state bus: each accepted row lands in its own COLS-wide slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid_q <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_accept && (row_idx_q == IDX_W'(r))) begin
                    grid_q[r*COLS +: COLS] <= row_data;
                end
            end
        end
    end

    assign grid_state_0 = grid_q;
    assign grid_rst     = grid_rst_q;
    assign grid_ena     = grid_ena_q;
    assign gen_count    = gen_count_q;
    assign state        = state_q;
    assign done         = done_q;
    assign stable       = stable_q;

endmodule

// File: tb/tb_conway_gen_controller.sv
// Testbench for conway_gen_controller: directed load/run/pause/step/wrap/reset/still-life
// sequences; expected grid_ena pulses (gen_count and spacing) are queued by the driver
// and checked by an independent monitor.
module tb_conway_gen_controller;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int TICK_W = 24;
  localparam int GEN_W  = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_INIT = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 pause;
  logic                 step;
  logic [TICK_W-1:0]    period;
  logic [GEN_W-1:0]     max_gen;
  logic [COLS-1:0]      row_data;
  logic                 row_valid;
  logic                 row_ready;
  logic                 grid_changed;
  logic [ROWS*COLS-1:0] grid_state_0;
  logic                 grid_rst;
  logic                 grid_ena;
  logic [GEN_W-1:0]     gen_count;
  logic [2:0]           state;
  logic                 done;
  logic                 stable;

  conway_gen_controller #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .TICK_W (TICK_W),
    .GEN_W  (GEN_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pause        (pause),
    .step         (step),
    .period       (period),
    .max_gen      (max_gen),
    .row_data     (row_data),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .grid_changed (grid_changed),
    .grid_state_0 (grid_state_0),
    .grid_rst     (grid_rst),
    .grid_ena     (grid_ena),
    .gen_count    (gen_count),
    .state        (state),
    .done         (done),
    .stable       (stable)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [GEN_W-1:0] exp_q[$];
  int               gap_q[$];
  int               checks = 0;
  int               errors = 0;
  int               last_pulse = 0;
  logic [COLS-1:0]  pat [ROWS];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [ROWS*COLS-1:0] pack_pat();
    logic [ROWS*COLS-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++) v[r*COLS +: COLS] = pat[r];
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [GEN_W-1:0] e;
    int g;
    if (rst_n) begin
      check("row_ready_only_in_load", {63'd0, row_ready}, {63'd0, state == S_LOAD});
    end
    if (grid_ena) begin
      check("ena_without_rst", {63'd0, grid_rst}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got pulse gen_count=%0h at cycle %0d expected none", gen_count, cyc);
      end else begin
        e = exp_q.pop_front();
        g = gap_q.pop_front();
        check("pulse_gen_count", {56'd0, gen_count}, {56'd0, e});
        if (g != 0) check("pulse_spacing", 64'(cyc - last_pulse), 64'(g));
      end
      last_pulse = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [GEN_W-1:0] gen, input int gap);
    exp_q.push_back(gen);
    gap_q.push_back(gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic load_rows(input int n, input int gap_mod);
    int b;
    for (int r = 0; r < n; r++) begin
      row_valid = 1'b0;
      if (gap_mod > 0) tick(r % gap_mod);
      row_data  = pat[r];
      row_valid = 1'b1;
      b = 0;
      while (!row_ready && b < 50) begin
        tick(1);
        b++;
      end
      if (!row_ready) check("row_ready_timeout", 64'd0, 64'd1);
      tick(1);
      row_valid = 1'b0;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int b = 0;
    while (state !== s && b < budget) begin
      tick(1);
      b++;
    end
    check(name, {61'd0, state}, {61'd0, s});
  endtask

  task automatic wait_queue_below(input int n, input int budget, input string name);
    int b = 0;
    while (exp_q.size() >= n && b < budget) begin
      tick(1);
      b++;
    end
    check(name, 64'(exp_q.size() < n), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; step = 1'b0;
    period = 24'd4; max_gen = 8'd3; row_data = '0; row_valid = 1'b0;
    grid_changed = 1'b1;

    // Reset values
    tick(3);
    check("rst_state", {61'd0, state}, {61'd0, S_IDLE});
    check("rst_grid_rst", {63'd0, grid_rst}, 64'd1);
    check("rst_grid_ena", {63'd0, grid_ena}, 64'd0);
    check("rst_row_ready", {63'd0, row_ready}, 64'd0);
    check("rst_grid_state_0", grid_state_0, 64'd0);
    check("rst_gen_count", {56'd0, gen_count}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_stable", {63'd0, stable}, 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Glider load with gaps, period 4, limit 3
    pat = '{8'h02, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_exp(8'd1, 0); push_exp(8'd2, 4); push_exp(8'd3, 4);
    pulse_start();
    check("load_state", {61'd0, state}, {61'd0, S_LOAD});
    check("load_grid_rst", {63'd0, grid_rst}, 64'd1);
    load_rows(ROWS, 3);
    check("init_state", {61'd0, state}, {61'd0, S_INIT});
    check("init_grid_rst", {63'd0, grid_rst}, 64'd1);
    check("init_no_more_rows", {63'd0, row_ready}, 64'd0);
    check("glider_grid_state_0", grid_state_0, pack_pat());
    tick(1);
    check("run_state", {61'd0, state}, {61'd0, S_RUN});
    check("run_grid_rst", {63'd0, grid_rst}, 64'd0);
    wait_state(S_HALT, 100, "limit_halt");
    check("limit_done", {63'd0, done}, 64'd1);
    check("limit_gen_count", {56'd0, gen_count}, 64'd3);
    check("limit_stable", {63'd0, stable}, 64'd0);
    check("halt_grid_rst", {63'd0, grid_rst}, 64'd0);
    tick(12);
    check("halt_holds_gen", {56'd0, gen_count}, 64'd3);

    // Pause on the expiry cycle, then three steps, then resume
    pat = '{8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    max_gen = 8'd0;
    pulse_start();
    check("restart_from_halt", {61'd0, state}, {61'd0, S_LOAD});
    check("restart_clears_done", {63'd0, done}, 64'd0);
    load_rows(ROWS, 0);
    tick(1);
    check("run2_state", {61'd0, state}, {61'd0, S_RUN});
    tick(3);
    pause = 1'b1;
    tick(3);
    check("paused_no_pulse_gen", {56'd0, gen_count}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      push_exp(GEN_W'(i + 1), (i == 0) ? 0 : 2);
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(1);
    end
    check("steps_gen_count", {56'd0, gen_count}, 64'd3);
    tick(2);
    push_exp(8'd4, 0);
    pause = 1'b0;
    tick(1);
    check("resume_fires_expiry", {63'd0, grid_ena}, 64'd1);
    push_exp(8'd5, 4);
    tick(4);
    check("resume_next_period", {63'd0, grid_ena}, 64'd1);
    pause = 1'b1;
    tick(2);

    // period 0 then 1, unlimited: pulse every 2 cycles and gen_count wraps
    row_valid = 1'b1;
    row_data  = 8'hFF;
    for (int k = 6; k <= 258; k++) push_exp(GEN_W'(k), (k == 6) ? 0 : 2);
    period = 24'd0;
    pause  = 1'b0;
    wait_queue_below(125, 1000, "period0_progress");
    period = 24'd1;
    wait_queue_below(1, 1000, "period1_drain");
    pause = 1'b1;
    tick(3);
    check("wrap_gen_count", {56'd0, gen_count}, 64'd2);
    check("wrap_no_halt", {61'd0, state}, {61'd0, S_RUN});
    check("rows_ignored_outside_load", grid_state_0, pack_pat());
    row_valid = 1'b0;
    pulse_start();
    check("start_ignored_in_run", {61'd0, state}, {61'd0, S_RUN});

    // Reset in the middle of a load
    rst_n = 1'b0;
    #1;
    check("midrun_rst_state", {61'd0, state}, {61'd0, S_IDLE});
    check("midrun_rst_gen", {56'd0, gen_count}, 64'd0);
    rst_n = 1'b1;
    tick(1);
    pat = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    pulse_start();
    load_rows(3, 0);
    rst_n = 1'b0;
    #1;
    check("midload_rst_state", {61'd0, state}, {61'd0, S_IDLE});
    check("midload_rst_grid", grid_state_0, 64'd0);
    check("midload_rst_row_ready", {63'd0, row_ready}, 64'd0);
    check("midload_rst_grid_rst", {63'd0, grid_rst}, 64'd1);
    rst_n = 1'b1;
    tick(1);
    pat = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h3C, 8'h5A, 8'hA5, 8'hC3};
    pause = 1'b0; period = 24'd2; max_gen = 8'd3;
    push_exp(8'd1, 0); push_exp(8'd2, 2); push_exp(8'd3, 2);
    pulse_start();
    load_rows(ROWS, 2);
    check("fresh_grid_state_0", grid_state_0, pack_pat());
    wait_state(S_HALT, 100, "fresh_halt");
    check("fresh_gen_count", {56'd0, gen_count}, 64'd3);

    // Still life (block)
    pat = '{8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00};
    grid_changed = 1'b0;
`ifdef CONWAY_STABLE_DETECT_EN
    max_gen = 8'd1;
    push_exp(8'd1, 0);
    pulse_start();
    load_rows(ROWS, 0);
    wait_state(S_HALT, 100, "still_halt");
    check("still_stable", {63'd0, stable}, 64'd1);
    check("still_done", {63'd0, done}, 64'd1);
    check("still_gen_count", {56'd0, gen_count}, 64'd1);
`else
    max_gen = 8'd0;
    push_exp(8'd1, 0); push_exp(8'd2, 2); push_exp(8'd3, 2); push_exp(8'd4, 2);
    pulse_start();
    load_rows(ROWS, 0);
    wait_queue_below(1, 200, "still_keeps_running");
    pause = 1'b1;
    tick(2);
    check("still_state_run", {61'd0, state}, {61'd0, S_RUN});
    check("still_stable_zero", {63'd0, stable}, 64'd0);
    check("still_done_zero", {63'd0, done}, 64'd0);
    check("still_gen_count", {56'd0, gen_count}, 64'd4);
`endif

    tick(6);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
